// File: rtl/axis_arb_pkg.sv
// Shared state encodings and width helpers for the packet round-robin AXIS arbiter.
package axis_arb_pkg;

  typedef logic [0:0] state_t;

  localparam state_t IDLE = 1'b0;
  localparam state_t BUSY = 1'b1;

  // Index width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first asserted request scanning from ptr upward, wrapping.
module rr_pick
  import axis_arb_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 2,
  parameter int unsigned SEL_W      = clog2_min1(NUM_SLAVES)
) (
  input  logic [NUM_SLAVES-1:0] req,
  input  logic [SEL_W-1:0]      ptr,
  output logic                  valid,
  output logic [SEL_W-1:0]      idx
);

  always_comb begin
    int unsigned cand;
    valid = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      cand = (32'(ptr) + i) % NUM_SLAVES;
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = SEL_W'(cand);
      end
    end
  end

endmodule

// File: rtl/axis_pkt_rr_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXIS master among NUM_SLAVES slaves.
// Optional AXIS_ARB_TLAST_EN adds m00_axis_tlast on the final beat of each packet.
module axis_pkt_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int unsigned NUM_SLAVES         = 2,
  parameter int unsigned C_AXIS_TDATA_WIDTH = 8,
  parameter int unsigned PKT_WORDS          = 20
) (
  input  logic                                     aclk,
  input  logic                                     areset,
  input  logic [NUM_SLAVES-1:0]                    s_axis_tvalid,
  input  logic [NUM_SLAVES*C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  output logic [NUM_SLAVES-1:0]                    s_axis_tready,
  output logic                                     m00_axis_tvalid,
  output logic [C_AXIS_TDATA_WIDTH-1:0]            m00_axis_tdata,
  input  logic                                     m00_axis_tready,
`ifdef AXIS_ARB_TLAST_EN
  output logic                                     m00_axis_tlast,
`endif
  output logic [NUM_SLAVES-1:0]                    grant,
  output logic                                     busy
);

  localparam int unsigned SEL_W = clog2_min1(NUM_SLAVES);
  localparam int unsigned CNT_W = clog2_min1(PKT_WORDS);
  localparam int unsigned W     = C_AXIS_TDATA_WIDTH;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(PKT_WORDS - 1);
  localparam logic [SEL_W-1:0] LAST_SEL  = SEL_W'(NUM_SLAVES - 1);

  state_t             state, state_n;
  logic [SEL_W-1:0]   sel, sel_n;
  logic [SEL_W-1:0]   ptr, ptr_n;
  logic [CNT_W-1:0]   beat_cnt, beat_cnt_n;

  logic               pick_valid;
  logic [SEL_W-1:0]   pick_idx;
  logic               xfer_c;
  logic               last_beat_c;

  rr_pick #(
    .NUM_SLAVES (NUM_SLAVES),
    .SEL_W      (SEL_W)
  ) u_pick (
    .req   (s_axis_tvalid),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign last_beat_c = (beat_cnt == LAST_BEAT);
  assign xfer_c      = (state == BUSY) && s_axis_tvalid[sel] && m00_axis_tready;

  // State and bookkeeping registers.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state    <= IDLE;
      sel      <= '0;
      ptr      <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_n;
      sel      <= sel_n;
      ptr      <= ptr_n;
      beat_cnt <= beat_cnt_n;
    end
  end

  // Next-state: arbitrate in IDLE, count handshakes in BUSY, rotate priority after each packet.
  always_comb begin
    state_n    = state;
    sel_n      = sel;
    ptr_n      = ptr;
    beat_cnt_n = beat_cnt;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          sel_n      = pick_idx;
          beat_cnt_n = '0;
          state_n    = BUSY;
        end
      end
      BUSY: begin
        if (xfer_c) begin
          if (last_beat_c) begin
            state_n    = IDLE;
            beat_cnt_n = '0;
            ptr_n      = (sel == LAST_SEL) ? '0 : SEL_W'(sel + 1'b1);
          end else begin
            beat_cnt_n = CNT_W'(beat_cnt + 1'b1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Zero-latency routing of the granted slave; everything forced low outside BUSY so idle X data never leaks.
  always_comb begin
    s_axis_tready   = '0;
    m00_axis_tvalid = 1'b0;
    m00_axis_tdata  = '0;
    grant           = '0;
    busy            = 1'b0;
`ifdef AXIS_ARB_TLAST_EN
    m00_axis_tlast  = 1'b0;
`endif
    if (state == BUSY) begin
      m00_axis_tvalid    = s_axis_tvalid[sel];
      m00_axis_tdata     = s_axis_tdata[32'(sel)*W +: W];
      s_axis_tready[sel] = m00_axis_tready;
      grant[sel]         = 1'b1;
      busy               = 1'b1;
`ifdef AXIS_ARB_TLAST_EN
      m00_axis_tlast     = last_beat_c;
`endif
    end
  end

endmodule

// File: tb/tb_axis_pkt_rr_arbiter.sv
// Directed scoreboard bench for axis_pkt_rr_arbiter (2 slaves, 8-bit data, 20-beat packets).
module tb_axis_pkt_rr_arbiter;

  localparam int unsigned NS = 2;
  localparam int unsigned W  = 8;
  localparam int unsigned PW = 20;

  typedef struct {
    logic [NS-1:0] g;
    logic [W-1:0]  d;
    logic          last;
  } exp_t;

  logic             clk = 1'b0;
  logic             areset;
  logic [NS-1:0]    s_tvalid;
  logic [NS*W-1:0]  s_tdata;
  logic [NS-1:0]    s_tready;
  logic             m_tvalid;
  logic [W-1:0]     m_tdata;
  logic             m_tready;
  logic [NS-1:0]    grant;
  logic             busy;
`ifdef AXIS_ARB_TLAST_EN
  logic             m_tlast;
`endif

  axis_pkt_rr_arbiter #(
    .NUM_SLAVES         (NS),
    .C_AXIS_TDATA_WIDTH (W),
    .PKT_WORDS          (PW)
  ) dut (
    .aclk            (clk),
    .areset          (areset),
    .s_axis_tvalid   (s_tvalid),
    .s_axis_tdata    (s_tdata),
    .s_axis_tready   (s_tready),
    .m00_axis_tvalid (m_tvalid),
    .m00_axis_tdata  (m_tdata),
    .m00_axis_tready (m_tready),
`ifdef AXIS_ARB_TLAST_EN
    .m00_axis_tlast  (m_tlast),
`endif
    .grant           (grant),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  // Source models
  int         rem [NS];
  logic [W-1:0] nd [NS];
  int         sent [NS];
  int         gap_after [NS];
  int         gap_cnt [NS];
  logic       bp;
  logic       exp_bubble;
  int         nxfer;

  // Values sampled at the last negedge
  logic [NS-1:0] grant_s, sready_s;
  logic          busy_s, mtv_s, mtr_s, gap0_s;
  logic [W-1:0]  mtd_s;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_sources();
    for (int i = 0; i < NS; i++) begin
      s_tvalid[i] = (rem[i] > 0) && (gap_cnt[i] == 0);
      s_tdata[i*W +: W] = s_tvalid[i] ? nd[i] : 'x;
    end
  endtask

  task automatic load(input int s, input int n, input logic [W-1:0] base);
    rem[s]  = n;
    nd[s]   = base;
    sent[s] = 0;
  endtask

  task automatic push_pkt(input int s, input logic [W-1:0] base);
    exp_t e;
    for (int k = 0; k < PW; k++) begin
      e.g    = NS'(1 << s);
      e.d    = W'(base + k);
      e.last = (k == PW - 1);
      sb.push_back(e);
    end
  endtask

  // One clock: sample/check at negedge, then update sources just after posedge.
  task automatic step();
    logic [NS-1:0] hs;
    exp_t e;
    @(negedge clk);
    grant_s  = grant;
    busy_s   = busy;
    mtv_s    = m_tvalid;
    mtd_s    = m_tdata;
    sready_s = s_tready;
    mtr_s    = m_tready;
    gap0_s   = (gap_cnt[0] > 0);
    hs       = s_tvalid & s_tready;
    if (exp_bubble) begin
      chk("bubble_busy", 32'(busy), 0);
      exp_bubble = 1'b0;
    end
    if (busy !== 1'b1) begin
      chk("idle_grant", 32'(grant), 0);
      chk("idle_tvalid", 32'(m_tvalid), 0);
      chk("idle_tdata", 32'(m_tdata), 0);
      chk("idle_tready", 32'(s_tready), 0);
`ifdef AXIS_ARB_TLAST_EN
      chk("idle_tlast", 32'(m_tlast), 0);
`endif
    end
    if (m_tvalid && m_tready) begin
      nxfer++;
      chk("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("beat_data", 32'(m_tdata), 32'(e.d));
        chk("beat_grant", 32'(grant), 32'(e.g));
`ifdef AXIS_ARB_TLAST_EN
        chk("beat_tlast", 32'(m_tlast), 32'(e.last));
`endif
        if (e.last) exp_bubble = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NS; i++) begin
      if (hs[i]) begin
        nd[i]++;
        rem[i]--;
        sent[i]++;
        if (sent[i] == gap_after[i]) gap_cnt[i] = 5;
      end else if (gap_cnt[i] > 0) begin
        gap_cnt[i]--;
      end
    end
    if (bp) m_tready = !m_tready;
    drive_sources();
  endtask

  task automatic run_until_empty(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk("drain", 32'(sb.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, bud, ngap;
    areset     = 1'b1;
    m_tready   = 1'b1;
    bp         = 1'b0;
    exp_bubble = 1'b0;
    nxfer      = 0;
    for (int i = 0; i < NS; i++) begin
      rem[i] = 0; nd[i] = '0; sent[i] = 0; gap_after[i] = -1; gap_cnt[i] = 0;
    end
    drive_sources();

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tvalid", 32'(m_tvalid), 0);
    chk("rst_tdata", 32'(m_tdata), 0);
    chk("rst_tready", 32'(s_tready), 0);
    @(posedge clk);
    #1;
    areset = 1'b0;

    // 1: single requester, one-cycle arbitration latency
    load(0, PW, 8'd0);
    push_pkt(0, 8'd0);
    drive_sources();
    step();
    chk("t1_grant_lat0", 32'(grant_s), 0);
    step();
    chk("t1_grant_lat1", 32'(grant_s), 32'(2'b01));
    run_until_empty(60);
    step();

    // 1b: ptr now 1, so slave1 wins a simultaneous request
    load(0, PW, 8'd40);
    load(1, PW, 8'd60);
    push_pkt(1, 8'd60);
    push_pkt(0, 8'd40);
    drive_sources();
    run_until_empty(100);
    step();

    // 2: contention from reset release, alternating grants for 4 packets
    areset = 1'b1;
    for (int i = 0; i < NS; i++) begin rem[i] = 0; gap_cnt[i] = 0; end
    drive_sources();
    @(posedge clk);
    #1;
    areset = 1'b0;
    sb.delete();
    exp_bubble = 1'b0;
    load(0, 2*PW, 8'd0);
    load(1, 2*PW, 8'd100);
    push_pkt(0, 8'd0);
    push_pkt(1, 8'd100);
    push_pkt(0, 8'd20);
    push_pkt(1, 8'd120);
    drive_sources();
    run_until_empty(200);
    step();

    // 3: back-pressure toggling during slave1's packet
    load(1, PW, 8'd150);
    push_pkt(1, 8'd150);
    bp = 1'b1;
    drive_sources();
    n0  = nxfer;
    bud = 0;
    step();
    while (grant_s !== 2'b10 && bud < 10) begin
      step();
      bud++;
    end
    chk("t3_grant", 32'(grant_s), 32'(2'b10));
    for (int c = 0; c < 40; c++) begin
      if (c != 0) step();
      if (busy_s) begin
        chk("t3_tready1_mirror", 32'(sready_s[1]), 32'(mtr_s));
        chk("t3_tready0_low", 32'(sready_s[0]), 0);
      end
    end
    chk("t3_xfers_in_40", 32'(nxfer - n0), 20);
    bp = 1'b0;
    m_tready = 1'b1;
    run_until_empty(10);
    step();

    // 4: slave0 gaps 5 cycles after beat 7 while slave1 requests
    gap_after[0] = 8;
    load(0, PW, 8'd0);
    load(1, PW, 8'd100);
    push_pkt(0, 8'd0);
    push_pkt(1, 8'd100);
    drive_sources();
    ngap = 0;
    bud  = 0;
    while (sb.size() != 0 && bud < 120) begin
      step();
      bud++;
      if (gap0_s) begin
        ngap++;
        chk("t4_gap_grant", 32'(grant_s), 32'(2'b01));
        chk("t4_gap_tvalid", 32'(mtv_s), 0);
      end
    end
    chk("t4_drain", 32'(sb.size()), 0);
    chk("t4_gap_cycles", 32'(ngap), 5);
    gap_after[0] = -1;
    step();

    // 5: reset at beat 10, then ptr=0 means slave0 wins
    load(0, PW, 8'd0);
    push_pkt(0, 8'd0);
    drive_sources();
    n0  = nxfer;
    bud = 0;
    while ((nxfer - n0) < 10 && bud < 40) begin
      step();
      bud++;
    end
    chk("t5_beats_before_rst", 32'(nxfer - n0), 10);
    m_tready = 1'b0;
    areset   = 1'b1;
    step();
    areset = 1'b0;
    sb.delete();
    exp_bubble = 1'b0;
    for (int i = 0; i < NS; i++) gap_cnt[i] = 0;
    m_tready = 1'b1;
    load(0, PW, 8'd200);
    load(1, PW, 8'd50);
    push_pkt(0, 8'd200);
    push_pkt(1, 8'd50);
    drive_sources();
    step();
    chk("t5_grant", 32'(grant_s), 0);
    chk("t5_busy", 32'(busy_s), 0);
    chk("t5_tvalid", 32'(mtv_s), 0);
    chk("t5_tready", 32'(sready_s), 0);
    step();
    chk("t5_first_winner", 32'(grant_s), 32'(2'b01));
    run_until_empty(100);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
